// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one RAM controller port between instruction fetch and the
// load/store unit. Each port's request is latched into its own pending
// register. The arbiter grants one request at a time. It issues a one-cycle
// ram_read/ram_write strobe and routes the RAM response back to the port
// that owns the transaction. grant_data replaces the old address-bus mux
// control.
//
// Optional build macro:
//   MEM_ARB_RR_EN - when defined, a tie between both pending ports is
//                   resolved round-robin: the port not granted last wins.
//                   When undefined, the data port always beats fetch.
//
// Ports:
//   clk, rst             clock (posedge), synchronous active-high reset
//   f_req/f_addr         fetch request pulse and address
//   f_abort              cancel outstanding fetch (PC changed)
//   f_ready/f_data       fetch completion pulse and fetched word (held)
//   f_busy               fetch pending or in flight
//   d_req/d_we/d_addr    data request pulse, write enable, address
//   d_wdata              data write value
//   d_ready/d_rdata      data completion pulse and read value (held)
//   d_busy               data pending or in flight
//   ram_read/ram_write   one-cycle strobes to the RAM controller
//   ram_addr/ram_wdata   address / write data, held for the transaction
//   ram_rdata/ram_ready  RAM response word and completion pulse
//   ram_busy             RAM cannot accept a strobe this cycle
//   grant_data           1 while the data port owns the RAM
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int WDATA_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_req,
  input  logic [ADDR_W-1:0]  f_addr,
  input  logic               f_abort,
  output logic               f_ready,
  output logic [DATA_W-1:0]  f_data,
  output logic               f_busy,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [WDATA_W-1:0] d_wdata,
  output logic               d_ready,
  output logic [WDATA_W-1:0] d_rdata,
  output logic               d_busy,
  output logic               ram_read,
  output logic               ram_write,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [WDATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  input  logic               ram_ready,
  input  logic               ram_busy,
  output logic               grant_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_next;

  logic               f_pend;
  logic [ADDR_W-1:0]  f_pend_addr;
  logic               d_pend;
  logic               d_pend_we;
  logic [ADDR_W-1:0]  d_pend_addr;
  logic [WDATA_W-1:0] d_pend_wdata;

  logic cur_we;
  logic abort_flag;
  logic in_flight;
  logic f_elig;
  logic data_prio;
  logic pick_data;
  logic grant_now;
  logic issue_ok;

`ifdef MEM_ARB_RR_EN
  logic last_grant_data;
`endif

  // A port is busy while its request waits in the pending register or
  // while it owns the transaction currently in ISSUE/WAIT.
  assign in_flight = (state != IDLE);
  assign f_busy    = f_pend | (in_flight & ~grant_data);
  assign d_busy    = d_pend | (in_flight &  grant_data);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic, arbitration and strobes. A fetch being aborted in
  // this very cycle is not eligible for a grant. The strobe lasts exactly
  // the single ISSUE cycle. If ram_busy is seen high in ISSUE, the strobe
  // was rejected, so the FSM falls back to IDLE and retries.
  always_comb begin
    state_next = state;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    grant_now  = 1'b0;
    issue_ok   = 1'b0;
    f_elig     = f_pend & ~f_abort;
`ifdef MEM_ARB_RR_EN
    data_prio  = ~last_grant_data;
`else
    data_prio  = 1'b1;
`endif
    pick_data  = d_pend & (~f_elig | data_prio);
    case (state)
      IDLE: begin
        if (!ram_busy && (d_pend || f_elig)) begin
          grant_now  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        ram_read  = ~cur_we;
        ram_write =  cur_we;
        if (ram_busy) begin
          state_next = IDLE;
        end else begin
          issue_ok   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (ram_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture. A pending entry stays set through ISSUE. It is
  // cleared only once the strobe has been accepted, so a rejected strobe
  // retries automatically. f_abort drops the old fetch. A simultaneous
  // f_req is then captured as the new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pend       <= 1'b0;
      f_pend_addr  <= '0;
      d_pend       <= 1'b0;
      d_pend_we    <= 1'b0;
      d_pend_addr  <= '0;
      d_pend_wdata <= '0;
    end else begin
      if (f_abort || (issue_ok && !grant_data)) f_pend <= 1'b0;
      if (f_req && (!f_busy || f_abort)) begin
        f_pend      <= 1'b1;
        f_pend_addr <= f_addr;
      end
      if (issue_ok && grant_data) d_pend <= 1'b0;
      if (d_req && !d_busy) begin
        d_pend       <= 1'b1;
        d_pend_we    <= d_we;
        d_pend_addr  <= d_addr;
        d_pend_wdata <= d_wdata;
      end
    end
  end

  // Grant datapath, abort tracking and response routing. Ownership is
  // dropped when the FSM returns to IDLE. The address is left as it was.
  // A response to an aborted fetch is consumed without f_ready and
  // without touching f_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_data <= 1'b0;
      cur_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      abort_flag <= 1'b0;
      f_ready    <= 1'b0;
      d_ready    <= 1'b0;
      f_data     <= '0;
      d_rdata    <= '0;
    end else begin
      f_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_now) begin
        grant_data <= pick_data;
        cur_we     <= pick_data & d_pend_we;
        ram_addr   <= pick_data ? d_pend_addr : f_pend_addr;
        ram_wdata  <= pick_data ? d_pend_wdata : '0;
      end else if (state_next == IDLE) begin
        grant_data <= 1'b0;
      end
      if (state_next == IDLE)
        abort_flag <= 1'b0;
      else if (f_abort && in_flight && !grant_data)
        abort_flag <= 1'b1;
      if (state == WAIT && ram_ready) begin
        if (grant_data) begin
          d_ready <= 1'b1;
          if (!cur_we) d_rdata <= ram_rdata[WDATA_W-1:0];
        end else if (!(abort_flag || f_abort)) begin
          f_ready <= 1'b1;
          f_data  <= ram_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin history: remembers which port owned the last ISSUE.
  always_ff @(posedge clk) begin
    if (rst)                 last_grant_data <= 1'b0;
    else if (state == ISSUE) last_grant_data <= grant_data;
  end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single RAM controller port between instruction fetch and the load/store (data) unit. It latches requests from both ports, grants one at a time, and drives the registered one-cycle RAM read/write strobes and the address/write-data mux. It routes the RAM response back to the owning port. It sits between the core (fetch, memory stage) and the SDRAM/SRAM controller and replaces ad-hoc addr_bus_mux_ctl steering.

Parameters:
ADDR_W, 16, address width of both requesters and RAM port
DATA_W, 32, RAM read-data width (fetch instruction width)
WDATA_W, 16, data-port write/read width (low bits of RAM word)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
f_req  input  1  fetch request pulse, address valid same cycle
f_addr  input  ADDR_W  fetch address
f_abort  input  1  cancel outstanding fetch (PC changed)
f_ready  output  1  one-cycle pulse, f_data valid
f_data  output  DATA_W  fetched word, held until next f_ready
f_busy  output  1  fetch pending or in flight
d_req  input  1  data request pulse
d_we  input  1  1=write, 0=read, sampled with d_req
d_addr  input  ADDR_W  data address
d_wdata  input  WDATA_W  write data
d_ready  output  1  one-cycle pulse, access complete (d_rdata valid on reads)
d_rdata  output  WDATA_W  read data, held until next d_ready
d_busy  output  1  data pending or in flight
ram_read  output  1  one-cycle read strobe
ram_write  output  1  one-cycle write strobe
ram_addr  output  ADDR_W  address to RAM, held for whole transaction
ram_wdata  output  WDATA_W  write data to RAM
ram_rdata  input  DATA_W  RAM read data
ram_ready  input  1  RAM response/completion pulse
ram_busy  input  1  RAM cannot accept a strobe this cycle
grant_data  output  1  1 while the data port owns the RAM (replaces mux ctl)

Behaviour:
- Reset: all outputs 0, both pending registers cleared, state IDLE, abort flag 0, last_grant=fetch.
- Request capture: x_req is sampled at posedge into a per-port pending register (addr, we, wdata). x_req while x_busy=1 is a protocol violation and is ignored (the first request wins).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if ~ram_busy and any pending -> select winner, drive ram_addr/ram_wdata/grant_data, go ISSUE. Requests captured on the same edge are not eligible until the next edge.
- ISSUE: ram_read (or ram_write for d_we=1) high for exactly this one cycle. Clear the winner's pending entry. Go WAIT.
- WAIT: ram_addr/ram_wdata/grant_data held. On ram_ready: latch ram_rdata into f_data or d_rdata[WDATA_W-1:0], pulse x_ready next cycle, go IDLE. If ram_busy is sampled high during ISSUE (strobe rejected), return to IDLE and restore the pending entry (retry); no x_ready.
- Latency: request at edge k -> strobe in cycle k+1..k+2 -> x_ready one cycle after ram_ready. Minimum req-to-ready is 3 cycles plus RAM latency.
- Priority (default): data beats fetch on simultaneous pending.
- f_abort: clears the fetch pending entry. If the fetch is in ISSUE/WAIT, set the abort flag; the response is consumed (state->IDLE) but f_ready is suppressed and f_data is unchanged. f_abort and f_req in the same cycle: abort applies to the old request, the new request is captured.
- f_busy/d_busy = pending | (in flight & owner == port); combinational from registers.
- ram_ready in IDLE/ISSUE is ignored.
- Reset mid-transaction: state IDLE, no x_ready. A late ram_ready after reset is ignored.
- Width: d_rdata = ram_rdata[WDATA_W-1:0]. ram_wdata = 0 on fetch grants.

Optional Feature:
MEM_ARB_RR_EN: when defined, ties are resolved round-robin. The port not granted last wins, and last_grant updates on each ISSUE. When undefined, fixed data-over-fetch priority applies and last_grant logic is absent.

Test Plan:
- Fetch only: f_req addr 0x0010, RAM ready after 2 cycles with 0xDEADBEEF -> single ram_read pulse, ram_addr=0x0010, one f_ready with f_data=0xDEADBEEF, f_busy drops the same cycle.
- Simultaneous f_req 0x0020 and d_req read 0x8000 -> data served first (grant_data=1, d_rdata=ram_rdata[15:0]), then fetch. With MEM_ARB_RR_EN and last_grant=data, fetch is served first.
- Write: d_req we=1 addr 0x1234 wdata 0xABCD -> ram_write single pulse, ram_wdata=0xABCD, d_ready after ram_ready, no ram_read.
- Abort in flight: f_req 0x0040, f_abort during WAIT, ram_ready returns 0x11111111 -> no f_ready, f_data keeps previous value. A following f_req 0x0041 is served normally.
- ram_busy high for 5 cycles while a fetch is pending -> no strobe until busy falls, then exactly one ram_read. Busy asserted during ISSUE -> retry, exactly one f_ready total.
- rst asserted in WAIT -> all outputs 0 next cycle. A later ram_ready produces no x_ready.
